// File: rtl/pac_pkg.sv
// Shared definitions for the Pac-Man motion engine: direction codes,
// FSM state encoding and small geometry helpers.
package pac_pkg;

   localparam logic [1:0] UP    = 2'd0;
   localparam logic [1:0] RIGHT = 2'd1;
   localparam logic [1:0] LEFT  = 2'd2;
   localparam logic [1:0] DOWN  = 2'd3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MOVE = 1'b1
   } pac_state_e;

   // Direction codes are laid out so that the reverse of d is 3-d.
   function automatic logic [1:0] opposite(input logic [1:0] d);
      return 2'd3 - d;
   endfunction

   function automatic logic signed [10:0] span(input int scale);
      return 11'(16 * scale);
   endfunction

endpackage

// File: rtl/pac_anim.sv
// Mouth-animation divider: advances a 0..3 frame index once every
// ANIM_DIV enabled ticks.
module pac_anim
   import pac_pkg::*;
#(
   parameter int ANIM_DIV = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       tick_en,
   output logic [2:0] frame
);

   localparam logic [3:0] DIV = 4'(ANIM_DIV);

   logic [3:0] cnt_r;
   logic [2:0] frame_r;

   // Tick counter and frame index, wrapping the frame after 3.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_r   <= 4'd0;
         frame_r <= 3'd0;
      end else if (tick_en) begin
         if (cnt_r + 4'd1 == DIV) begin
            cnt_r   <= 4'd0;
            frame_r <= (frame_r == 3'd3) ? 3'd0 : frame_r + 3'd1;
         end else begin
            cnt_r   <= cnt_r + 4'd1;
         end
      end
   end

   assign frame = frame_r;

endmodule

// File: rtl/pac_motion.sv
// Per-frame sprite movement: queued-turn resolution on the grid, edge
// wrap-around and the IDLE/MOVE start-up FSM. Animation lives in pac_anim.
module pac_motion
   import pac_pkg::*;
#(
   parameter int SPRITE_SCALE = 2,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int GRID         = 8,
   parameter int ANIM_DIV     = 2,
   parameter int START_X      = 304,
   parameter int START_Y      = 224
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               frame_tick,
   input  logic               dir_req_valid,
   input  logic [1:0]         dir_req,
   output logic signed [10:0] x_Pac,
   output logic signed [10:0] y_Pac,
   output logic [1:0]         pac_Direction,
   output logic [2:0]         pac_Frame,
   output logic               turn_pending
);

   localparam logic signed [10:0] S_POS   = span(SPRITE_SCALE);
   localparam logic signed [10:0] S_NEG   = -S_POS;
   localparam logic signed [10:0] X_MAX   = 11'(H_ACTIVE) + S_POS;
   localparam logic signed [10:0] Y_MAX   = 11'(V_ACTIVE) + S_POS;
   localparam logic signed [10:0] STEP    = 11'(SPRITE_SCALE);
   localparam logic signed [10:0] PITCH   = 11'(GRID * SPRITE_SCALE);
   localparam logic signed [10:0] X_START = 11'(START_X);
   localparam logic signed [10:0] Y_START = 11'(START_Y);

   pac_state_e         state_r;
   logic signed [10:0] x_r;
   logic signed [10:0] y_r;
   logic [1:0]         dir_r;
   logic [1:0]         pend_r;
   logic               pend_valid_r;

   logic signed [10:0] along_s;
   logic               aligned_s;
   logic [1:0]         dir_s;
   logic               clear_s;
   logic signed [10:0] x_s;
   logic signed [10:0] y_s;
   logic               move_tick_s;

   assign move_tick_s = frame_tick & (state_r == MOVE);

   // Resolve the queued request against the current heading.
   always_comb begin
      along_s   = y_r;
      if (dir_r == RIGHT || dir_r == LEFT) begin
         along_s = x_r;
      end else begin
         along_s = y_r;
      end
      aligned_s = ((along_s % PITCH) == 11'sd0);
      dir_s     = dir_r;
      clear_s   = 1'b0;
      if (pend_valid_r) begin
         if (pend_r == dir_r) begin
            clear_s = 1'b1;
         end else if (pend_r == opposite(dir_r)) begin
            dir_s   = pend_r;
            clear_s = 1'b1;
         end else if (aligned_s) begin
            dir_s   = pend_r;
            clear_s = 1'b1;
         end else begin
            dir_s   = dir_r;
            clear_s = 1'b0;
         end
      end else begin
         dir_s   = dir_r;
         clear_s = 1'b0;
      end
   end

   // Step along the resolved heading; a wrap replaces the step.
   always_comb begin
      x_s = x_r;
      y_s = y_r;
      case (dir_s)
         RIGHT:   x_s = (x_r >= X_MAX) ? S_NEG : x_r + STEP;
         LEFT:    x_s = (x_r <= S_NEG) ? X_MAX : x_r - STEP;
         DOWN:    y_s = (y_r >= Y_MAX) ? S_NEG : y_r + STEP;
         UP:      y_s = (y_r <= S_NEG) ? Y_MAX : y_r - STEP;
         default: begin
            x_s = x_r;
            y_s = y_r;
         end
      endcase
   end

   // FSM, position/heading and the pending-request register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r      <= IDLE;
         x_r          <= X_START;
         y_r          <= Y_START;
         dir_r        <= RIGHT;
         pend_r       <= UP;
         pend_valid_r <= 1'b0;
      end else begin
         if (state_r == IDLE && dir_req_valid) begin
            state_r <= MOVE;
         end
         if (move_tick_s) begin
            dir_r <= dir_s;
            x_r   <= x_s;
            y_r   <= y_s;
         end
         // A fresh request always wins over a clear from this tick.
         if (dir_req_valid) begin
            pend_r       <= dir_req;
            pend_valid_r <= 1'b1;
         end else if (move_tick_s && clear_s) begin
            pend_valid_r <= 1'b0;
         end
      end
   end

   pac_anim #(
      .ANIM_DIV (ANIM_DIV)
   ) u_anim (
      .CLK     (CLK),
      .RST     (RST),
      .tick_en (move_tick_s),
      .frame   (pac_Frame)
   );

   assign x_Pac         = x_r;
   assign y_Pac         = y_r;
   assign pac_Direction = dir_r;
   assign turn_pending  = pend_valid_r;

endmodule

// File: tb/tb_pac_motion.sv
// Bench for pac_motion: directed scenarios plus random traffic, all checked
// each cycle against an arithmetic reference model of the sprite.
module tb_pac_motion;
   import pac_pkg::*;

   localparam int SCALE = 2;
   localparam int PITCH = 16;
   localparam int SPAN  = 32;
   localparam int XMAX  = 672;
   localparam int YMAX  = 512;
   localparam int ADIV  = 2;

   logic               CLK = 1'b0;
   logic               RST = 1'b0;
   logic               frame_tick = 1'b0;
   logic               dir_req_valid = 1'b0;
   logic [1:0]         dir_req = 2'd0;
   logic signed [10:0] x_Pac;
   logic signed [10:0] y_Pac;
   logic [1:0]         pac_Direction;
   logic [2:0]         pac_Frame;
   logic               turn_pending;

   int n_checks = 0;
   int n_errors = 0;

   bit m_move;
   int m_x, m_y, m_dir, m_pend, m_ticks;
   bit m_pv;

   pac_motion dut (
      .CLK           (CLK),
      .RST           (RST),
      .frame_tick    (frame_tick),
      .dir_req_valid (dir_req_valid),
      .dir_req       (dir_req),
      .x_Pac         (x_Pac),
      .y_Pac         (y_Pac),
      .pac_Direction (pac_Direction),
      .pac_Frame     (pac_Frame),
      .turn_pending  (turn_pending)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit on_grid(input int c);
      return (((c % PITCH) + PITCH) % PITCH) == 0;
   endfunction

   task automatic model_reset();
      m_move  = 1'b0;
      m_x     = 304;
      m_y     = 224;
      m_dir   = 1;
      m_pend  = 0;
      m_pv    = 1'b0;
      m_ticks = 0;
   endtask

   task automatic model_step(input bit t, input bit v, input int d);
      bit clr;
      int nd;
      clr = 1'b0;
      if (t && m_move) begin
         nd = m_dir;
         if (m_pv) begin
            if (m_pend == m_dir) clr = 1'b1;
            else if (m_pend == 3 - m_dir) begin nd = m_pend; clr = 1'b1; end
            else if (on_grid((m_dir == 1 || m_dir == 2) ? m_x : m_y)) begin
               nd = m_pend; clr = 1'b1;
            end
         end
         m_dir = nd;
         case (nd)
            0: m_y = (m_y <= -SPAN) ? YMAX : m_y - SCALE;
            1: m_x = (m_x >= XMAX) ? -SPAN : m_x + SCALE;
            2: m_x = (m_x <= -SPAN) ? XMAX : m_x - SCALE;
            3: m_y = (m_y >= YMAX) ? -SPAN : m_y + SCALE;
            default: ;
         endcase
         m_ticks++;
      end
      if (v) begin
         m_pend = d;
         m_pv   = 1'b1;
         m_move = 1'b1;
      end else if (clr) begin
         m_pv = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".x"},     x_Pac,         m_x);
      chk({tag, ".y"},     y_Pac,         m_y);
      chk({tag, ".dir"},   pac_Direction, m_dir);
      chk({tag, ".frame"}, pac_Frame,     (m_ticks / ADIV) % 4);
      chk({tag, ".pend"},  turn_pending,  m_pv);
   endtask

   task automatic cyc(input bit t, input bit v, input int d, input string tag);
      frame_tick    = t;
      dir_req_valid = v;
      dir_req       = d[1:0];
      @(posedge CLK);
      #1;
      model_step(t, v, d);
      check_all(tag);
      frame_tick    = 1'b0;
      dir_req_valid = 1'b0;
   endtask

   task automatic tick(input string tag);
      cyc(1'b1, 1'b0, 0, tag);
      cyc(1'b0, 1'b0, 0, tag);
   endtask

   task automatic req(input int d, input string tag);
      cyc(1'b0, 1'b1, d, tag);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      #1;
      model_reset();
      check_all("reset");
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin : main
      int fexp [4];
      fexp = '{0, 1, 1, 2};
      #2;
      do_reset();

      // Stationary while idle
      repeat (3) tick("idle");
      chk("idle_x", x_Pac, 304);
      chk("idle_y", y_Pac, 224);
      chk("idle_frame", pac_Frame, 0);

      // Start moving right; frame sequence 0,1,1,2
      req(RIGHT, "start");
      for (int i = 0; i < 4; i++) begin
         tick("start");
         chk("start_frame", pac_Frame, fexp[i]);
         if (i == 0) chk("start_x1", x_Pac, 306);
      end
      chk("start_x4", x_Pac, 312);

      // Perpendicular turn waits for the grid
      do_reset();
      req(RIGHT, "perp");
      tick("perp");
      req(UP, "perp");
      chk("perp_pend", turn_pending, 1);
      repeat (7) tick("perp");
      chk("perp_x_wait", x_Pac, 320);
      chk("perp_pend_wait", turn_pending, 1);
      tick("perp");
      chk("perp_x", x_Pac, 320);
      chk("perp_y", y_Pac, 222);
      chk("perp_dir", pac_Direction, UP);
      chk("perp_pend_clr", turn_pending, 0);

      // Reverse is immediate
      do_reset();
      req(RIGHT, "rev");
      tick("rev");
      req(LEFT, "rev");
      tick("rev");
      chk("rev_dir", pac_Direction, LEFT);
      chk("rev_x", x_Pac, 304);
      chk("rev_pend", turn_pending, 0);

      // Wrap on the right and top edges
      do_reset();
      req(RIGHT, "wrap");
      repeat (184) tick("wrap");
      chk("wrap_x_edge", x_Pac, 672);
      tick("wrap");
      chk("wrap_x", x_Pac, -32);
      req(UP, "wrap");
      tick("wrap");
      chk("wrap_up_dir", pac_Direction, UP);
      chk("wrap_up_y", y_Pac, 222);
      repeat (127) tick("wrap");
      chk("wrap_y_edge", y_Pac, -32);
      tick("wrap");
      chk("wrap_y", y_Pac, 512);

      // Request coincident with tick uses the old pending value
      do_reset();
      req(RIGHT, "coin");
      repeat (8) tick("coin");
      chk("coin_x0", x_Pac, 320);
      cyc(1'b1, 1'b1, DOWN, "coin");
      chk("coin_x1", x_Pac, 322);
      chk("coin_dir", pac_Direction, RIGHT);
      chk("coin_pend", turn_pending, 1);
      cyc(1'b0, 1'b0, 0, "coin");
      repeat (7) tick("coin");
      chk("coin_x_wait", x_Pac, 336);
      tick("coin");
      chk("coin_turn_dir", pac_Direction, DOWN);
      chk("coin_turn_y", y_Pac, 226);
      chk("coin_turn_x", x_Pac, 336);

      // Asynchronous reset mid-motion, then idle behaviour
      #2;
      RST = 1'b1;
      #1;
      chk("arst_x", x_Pac, 304);
      chk("arst_y", y_Pac, 224);
      chk("arst_dir", pac_Direction, RIGHT);
      chk("arst_frame", pac_Frame, 0);
      chk("arst_pend", turn_pending, 0);
      model_reset();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      tick("post_rst");
      chk("post_rst_x", x_Pac, 304);

      // Random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                int'($urandom_range(0, 3)), "rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pac_motion.md
# pac_motion

Movement and animation engine for the Pac-Man sprite. Sits between the debounced button/direction logic and the colour-chooser stage. Once per video frame it advances the sprite position, applies any queued turn at a grid-legal moment, wraps at the screen edges and steps the mouth-animation frame. It produces the registered `x_Pac`, `y_Pac`, `pac_Direction` and `pac_Frame` that the colour chooser consumes.

## Interface
- `SPRITE_SCALE`, 2: pixel step per frame and sprite magnification; sprite span is `16*SPRITE_SCALE`.
- `UP`, `RIGHT`, `LEFT`, `DOWN`: 0, 1, 2, 3. Direction codes; the opposite of d is `3-d`.
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in pixels.
- `GRID`, 8: turn-alignment pitch in unscaled pixels; the effective pitch is `GRID*SPRITE_SCALE`.
- `ANIM_DIV`, 2: frame ticks per animation step (range 1..15).
- `START_X`, 304: reset x.
- `START_Y`, 224: reset y.
- `CLK` in 1: pixel clock, the only clock.
- `RST` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse at VGA position (0,0).
- `dir_req_valid` in 1: one-cycle strobe for a new direction request.
- `dir_req` in 2: requested direction code.
- `x_Pac` out 11 signed: sprite left edge.
- `y_Pac` out 11 signed: sprite top edge.
- `pac_Direction` out 2: current travel direction.
- `pac_Frame` out 3: animation frame, 0..3.
- `turn_pending` out 1: a queued turn is waiting.

## Operation
- FSM `IDLE` / `MOVE`.
  - Reset enters `IDLE`.
  - `IDLE`: the sprite is stationary and `pac_Frame` is held at 0.
  - The first accepted request moves the FSM to `MOVE`. That direction is applied at the next `frame_tick` unconditionally, since the start position is grid-aligned.
- Request capture: on `dir_req_valid`, store `dir_req` in the pending register and set `turn_pending`. A newer request overwrites an older one.
- Evaluation on `frame_tick` in `MOVE`, using the pending value registered before this cycle:
  - pending equals current direction: clear pending, no change.
  - pending is the opposite of current: apply immediately, clear pending.
  - pending is perpendicular: apply only if the coordinate along the current axis is a multiple of `GRID*SPRITE_SCALE`. Otherwise keep it pending.
- Movement: after direction resolution, step `SPRITE_SCALE` along the resolved direction in the same tick.
- Wrap, with span S = `16*SPRITE_SCALE`:
  - RIGHT: if x ≥ `H_ACTIVE+S`, set x = −S; otherwise x += step.
  - LEFT: if x ≤ −S, set x = `H_ACTIVE+S`.
  - DOWN and UP: same rules on y with `V_ACTIVE`.
  - Wrap replaces the step; no step is taken on a wrap tick.
- Arithmetic is 11-bit signed throughout. Every reachable value fits in [−S, `H_ACTIVE+S`].
- Animation: a 4-bit tick counter counts `frame_tick` events in `MOVE`. On reaching `ANIM_DIV` it resets to 0 and `pac_Frame` advances 0→1→2→3→0.

## Timing
- All outputs are registered and update on the `CLK` edge after `frame_tick` is sampled high. Latency is 1 cycle.
- Reset values:
  - `x_Pac` = `START_X`, `y_Pac` = `START_Y`
  - `pac_Direction` = `RIGHT`, `pac_Frame` = 0
  - `turn_pending` = 0, animation counter 0, state `IDLE`
- `dir_req_valid` coincident with `frame_tick`: the tick uses the old pending value, and the new request is stored afterwards for the next tick.
- A request strobe in `IDLE` coincident with `frame_tick` causes no motion on that tick.
- `RST` mid-frame: outputs return to reset values immediately (asynchronous). The first tick after release behaves as in `IDLE`.
- A `frame_tick` held high for more than one cycle is out of contract; each high cycle counts as a tick.

## Structure
- Shared package `pac_pkg` holds:
  - direction constants `UP`, `RIGHT`, `LEFT`, `DOWN`;
  - function `opposite(d)` = `3-d`;
  - function `span(scale)` = `16*scale`;
  - state enum `IDLE` / `MOVE`.
- The animation divider is one sub-module, `pac_anim`, with inputs `CLK`, `RST`, `tick_en` and output `frame[2:0]`. Position, turn logic and FSM stay in `pac_motion`.

## Test plan
1. Reset, then 3 ticks with no request → x=304, y=224, frame=0, state `IDLE`.
2. Request RIGHT, then 4 ticks → x after 1st tick = 306, after 4th = 312; frame sequence over ticks 1–4 = 0,1,1,2.
3. Moving RIGHT with x=306, request UP → `turn_pending`=1. The turn is applied at x=320, where y first decrements to 222, and `turn_pending` then clears.
4. Moving RIGHT with x=306, request LEFT → next tick direction=LEFT, x=304, pending cleared.
5. Moving RIGHT with x=672 → next tick x=−32. Moving UP with y=−32 → next tick y=512.
6. Request coincident with `frame_tick` while moving RIGHT at x=320, request DOWN → that tick x=322 with no turn. The turn is applied at x=336 on a later tick. Assert `RST` mid-motion → outputs return to 304/224/RIGHT/0 asynchronously.
